// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_bus_pkg
// Brief   : State encoding and bus size codes for the MEM-stage data bus.
// Rev     : 1.0
// ============================================================================
package mips_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } bus_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Size code 3 is not a legal bus size; it is issued as a word.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SIZE_WORD : size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_data_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_data_bus_ctrl_if
// Brief     : SRAM-like data bus (req/addr_ok, then data_ok) between controller and memory.
// Rev       : 1.0
// ============================================================================
interface mem_data_bus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_data_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mem_data_bus_ctrl
// Brief  : Turns the MEM-stage load/store into one bus transaction and reports completion.
// Rev    : 1.0
// ============================================================================
module mem_data_bus_ctrl
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              resetn,
    input  wire logic              mem_valid,
    input  wire logic              mem_ld,
    input  wire logic              mem_st,
    input  wire logic [1:0]        mem_size,
    input  wire logic [ADDR_W-1:0] mem_addr,
    input  wire logic [DATA_W-1:0] mem_wdata,
    input  wire logic              mem_advance,
    input  wire logic              mem_cancel,
    mem_data_bus_ctrl_if.master    bus,
    output logic                   mem_acc_ok,
    output logic [DATA_W-1:0]      mem_rdata,
    output logic                   busy
);

    bus_state_t        r_state, w_state_nxt;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_access;
    logic              w_latch_req;
    logic              w_capture;
    logic              w_req;
    logic              w_wr;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    assign w_access = mem_valid & (mem_ld | mem_st) & ~mem_cancel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_wr    <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_req) begin
                r_wr    <= mem_st;
                r_size  <= norm_size(mem_size);
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
            end
            if (w_capture) begin
                r_rdata <= bus.data_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch_req = 1'b0;
        w_capture   = 1'b0;
        w_req       = 1'b0;
        w_wr        = 1'b0;
        w_size      = '0;
        w_addr      = '0;
        w_wdata     = '0;
        mem_acc_ok  = 1'b0;
        mem_rdata   = '0;
        unique case (r_state)
            ST_IDLE: begin
                // Zero-cycle issue straight from the MEM-stage fields.
                if (w_access) begin
                    w_req       = 1'b1;
                    w_wr        = mem_st;
                    w_size      = norm_size(mem_size);
                    w_addr      = mem_addr;
                    w_wdata     = mem_wdata;
                    w_latch_req = 1'b1;
                    w_state_nxt = bus.data_addr_ok ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                w_req   = 1'b1;
                w_wr    = r_wr;
                w_size  = r_size;
                w_addr  = r_addr;
                w_wdata = r_wdata;
                if (bus.data_addr_ok) begin
                    w_state_nxt = mem_cancel ? ST_DRAIN : ST_WAIT;
                end else if (mem_cancel) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.data_data_ok) begin
                    if (!mem_cancel) begin
                        mem_acc_ok  = 1'b1;
                        mem_rdata   = bus.data_rdata;
                        w_capture   = 1'b1;
                        w_state_nxt = mem_advance ? ST_IDLE : ST_DONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (mem_cancel) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                mem_acc_ok = 1'b1;
                mem_rdata  = r_rdata;
                if (mem_advance || mem_cancel) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // A squashed access still owes the bus one response.
                if (bus.data_data_ok) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Keep the bus quiet while reset is held even if MEM still presents an access.
    assign bus.data_req   = resetn & w_req;
    assign bus.data_wr    = resetn & w_wr;
    assign bus.data_size  = resetn ? w_size  : '0;
    assign bus.data_addr  = resetn ? w_addr  : '0;
    assign bus.data_wdata = resetn ? w_wdata : '0;

    assign busy = (r_state == ST_REQ) || (r_state == ST_WAIT) || (r_state == ST_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_mem_data_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_data_bus_ctrl
// Brief  : Directed scoreboard bench for mem_data_bus_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_mem_data_bus_ctrl;

    typedef struct packed {
        logic        chk_data;
        logic [31:0] data;
    } rsp_t;

    logic        clk;
    logic        resetn;
    logic        mem_valid, mem_ld, mem_st, mem_advance, mem_cancel;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_acc_ok, busy;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [66:0] exp_req[$];
    rsp_t        exp_rsp[$];

    mem_data_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    mem_data_bus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_valid   (mem_valid),
        .mem_ld      (mem_ld),
        .mem_st      (mem_st),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_advance (mem_advance),
        .mem_cancel  (mem_cancel),
        .bus         (bif.master),
        .mem_acc_ok  (mem_acc_ok),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic issue(input logic st, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        mem_valid = 1'b1;
        mem_ld    = ~st;
        mem_st    = st;
        mem_size  = size;
        mem_addr  = addr;
        mem_wdata = wdata;
    endtask

    task automatic idle();
        mem_valid        = 1'b0;
        mem_ld           = 1'b0;
        mem_st           = 1'b0;
        mem_advance      = 1'b0;
        mem_cancel       = 1'b0;
        bif.data_addr_ok = 1'b0;
        bif.data_data_ok = 1'b0;
    endtask

    // Scoreboard monitor: bus handshakes and access completions.
    initial begin : monitor
        logic        acc_seen;
        logic [66:0] er;
        rsp_t        rr;
        acc_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (bif.data_req && bif.data_addr_ok) begin
                    if (exp_req.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req addr=%0h expected none", bif.data_addr);
                    end else begin
                        er = exp_req.pop_front();
                        chk("req_fields", {5'd0, bif.data_wr, bif.data_size, bif.data_addr, bif.data_wdata},
                            {5'd0, er});
                    end
                end
                if (mem_acc_ok && !acc_seen) begin
                    acc_seen = 1'b1;
                    if (exp_rsp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_acc rdata=%0h expected none", mem_rdata);
                    end else begin
                        rr = exp_rsp.pop_front();
                        if (rr.chk_data) chk("rsp_data", {40'd0, mem_rdata}, {40'd0, rr.data});
                    end
                end
                if (mem_acc_ok && (mem_advance || mem_cancel)) acc_seen = 1'b0;
            end else begin
                acc_seen = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        resetn          = 1'b0;
        mem_size        = 2'd0;
        mem_addr        = '0;
        mem_wdata       = '0;
        bif.data_rdata  = '0;
        idle();

        sample();
        chk("rst_req",   {71'd0, bif.data_req},   72'd0);
        chk("rst_wr",    {71'd0, bif.data_wr},    72'd0);
        chk("rst_addr",  {40'd0, bif.data_addr},  72'd0);
        chk("rst_acc",   {71'd0, mem_acc_ok},     72'd0);
        chk("rst_rdata", {40'd0, mem_rdata},      72'd0);
        chk("rst_busy",  {71'd0, busy},           72'd0);
        step();
        step();
        resetn = 1'b1;

        // LW, minimum latency, advance on completion
        issue(1'b0, 2'd2, 32'h1000, 32'h0);
        bif.data_addr_ok = 1'b1;
        exp_req.push_back({1'b0, 2'd2, 32'h1000, 32'h0});
        exp_rsp.push_back('{chk_data: 1'b1, data: 32'hDEADBEEF});
        sample();
        chk("t1_req", {71'd0, bif.data_req}, 72'd1);
        step();
        bif.data_addr_ok = 1'b0;
        bif.data_data_ok = 1'b1;
        bif.data_rdata   = 32'hDEADBEEF;
        mem_advance      = 1'b1;
        sample();
        chk("t1_req_drop", {71'd0, bif.data_req}, 72'd0);
        chk("t1_acc",      {71'd0, mem_acc_ok},   72'd1);
        chk("t1_busy",     {71'd0, busy},         72'd1);
        step();
        idle();
        sample();
        chk("t1_acc_clr",  {71'd0, mem_acc_ok},   72'd0);
        chk("t1_idle",     {71'd0, busy},         72'd0);

        // SB with delayed addr_ok; request must come from the latched register
        step();
        issue(1'b1, 2'd0, 32'h2003, 32'hAA000000);
        exp_req.push_back({1'b1, 2'd0, 32'h2003, 32'hAA000000});
        exp_rsp.push_back('{chk_data: 1'b0, data: 32'h0});
        for (int i = 0; i < 4; i++) begin
            bif.data_addr_ok = (i == 3);
            sample();
            chk("t2_req",   {71'd0, bif.data_req},   72'd1);
            chk("t2_wr",    {71'd0, bif.data_wr},    72'd1);
            chk("t2_size",  {70'd0, bif.data_size},  72'd0);
            chk("t2_addr",  {40'd0, bif.data_addr},  72'h2003);
            chk("t2_wdata", {40'd0, bif.data_wdata}, 72'hAA000000);
            chk("t2_acc",   {71'd0, mem_acc_ok},     72'd0);
            step();
            if (i == 0) begin
                mem_addr  = 32'hFFFF_FFFF;
                mem_wdata = 32'h0;
                mem_size  = 2'd2;
            end
        end
        bif.data_addr_ok = 1'b0;
        sample();
        chk("t2_wait_acc",  {71'd0, mem_acc_ok},   72'd0);
        chk("t2_wait_busy", {71'd0, busy},         72'd1);
        chk("t2_wait_req",  {71'd0, bif.data_req}, 72'd0);
        step();
        bif.data_data_ok = 1'b1;
        bif.data_rdata   = 32'h12345678;
        mem_advance      = 1'b1;
        sample();
        chk("t2_acc", {71'd0, mem_acc_ok}, 72'd1);
        step();
        idle();

        // LW completes without advance; result held in DONE
        issue(1'b0, 2'd2, 32'h3000, 32'h0);
        bif.data_addr_ok = 1'b1;
        exp_req.push_back({1'b0, 2'd2, 32'h3000, 32'h0});
        exp_rsp.push_back('{chk_data: 1'b1, data: 32'hCAFEF00D});
        sample();
        step();
        bif.data_addr_ok = 1'b0;
        bif.data_data_ok = 1'b1;
        bif.data_rdata   = 32'hCAFEF00D;
        sample();
        chk("t3_acc", {71'd0, mem_acc_ok}, 72'd1);
        step();
        bif.data_data_ok = 1'b0;
        bif.data_rdata   = 32'h0;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("t3_hold_acc",   {71'd0, mem_acc_ok}, 72'd1);
            chk("t3_hold_rdata", {40'd0, mem_rdata},  72'hCAFEF00D);
            chk("t3_hold_busy",  {71'd0, busy},       72'd0);
            chk("t3_hold_req",   {71'd0, bif.data_req}, 72'd0);
            step();
        end
        mem_advance = 1'b1;
        sample();
        chk("t3_adv_acc", {71'd0, mem_acc_ok}, 72'd1);
        step();
        idle();
        sample();
        chk("t3_acc_clr", {71'd0, mem_acc_ok}, 72'd0);

        // Cancel in WAIT -> DRAIN swallows the stale response
        step();
        issue(1'b0, 2'd2, 32'h4000, 32'h0);
        bif.data_addr_ok = 1'b1;
        exp_req.push_back({1'b0, 2'd2, 32'h4000, 32'h0});
        sample();
        step();
        bif.data_addr_ok = 1'b0;
        mem_cancel       = 1'b1;
        sample();
        chk("t4_cancel_acc", {71'd0, mem_acc_ok}, 72'd0);
        step();
        mem_cancel = 1'b0;
        issue(1'b0, 2'd2, 32'h5000, 32'h0);
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("t4_drain_busy", {71'd0, busy},         72'd1);
            chk("t4_drain_req",  {71'd0, bif.data_req}, 72'd0);
            chk("t4_drain_acc",  {71'd0, mem_acc_ok},   72'd0);
            step();
        end
        bif.data_data_ok = 1'b1;
        bif.data_rdata   = 32'hBAD0BAD0;
        sample();
        chk("t4_stale_acc", {71'd0, mem_acc_ok},   72'd0);
        chk("t4_stale_req", {71'd0, bif.data_req}, 72'd0);
        step();
        bif.data_data_ok = 1'b0;
        bif.data_addr_ok = 1'b1;
        exp_req.push_back({1'b0, 2'd2, 32'h5000, 32'h0});
        exp_rsp.push_back('{chk_data: 1'b1, data: 32'h55AA55AA});
        sample();
        chk("t4_new_req", {71'd0, bif.data_req}, 72'd1);
        step();
        bif.data_addr_ok = 1'b0;
        bif.data_data_ok = 1'b1;
        bif.data_rdata   = 32'h55AA55AA;
        mem_advance      = 1'b1;
        sample();
        chk("t4_new_acc", {71'd0, mem_acc_ok}, 72'd1);
        step();
        idle();

        // Cancel in REQ without addr_ok -> request withdrawn
        issue(1'b0, 2'd1, 32'h6000, 32'h0);
        sample();
        chk("t5_req", {71'd0, bif.data_req}, 72'd1);
        step();
        mem_cancel = 1'b1;
        sample();
        chk("t5_req_held", {71'd0, bif.data_req}, 72'd1);
        chk("t5_busy",     {71'd0, busy},         72'd1);
        step();
        idle();
        sample();
        chk("t5_req_drop", {71'd0, bif.data_req}, 72'd0);
        chk("t5_idle",     {71'd0, busy},         72'd0);

        // Reset mid-WAIT, then a fresh LW with size code 3
        step();
        issue(1'b0, 2'd2, 32'h7000, 32'h0);
        bif.data_addr_ok = 1'b1;
        exp_req.push_back({1'b0, 2'd2, 32'h7000, 32'h0});
        sample();
        step();
        bif.data_addr_ok = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_rst_req",   {71'd0, bif.data_req},   72'd0);
        chk("t6_rst_wr",    {71'd0, bif.data_wr},    72'd0);
        chk("t6_rst_size",  {70'd0, bif.data_size},  72'd0);
        chk("t6_rst_addr",  {40'd0, bif.data_addr},  72'd0);
        chk("t6_rst_wdata", {40'd0, bif.data_wdata}, 72'd0);
        chk("t6_rst_acc",   {71'd0, mem_acc_ok},     72'd0);
        chk("t6_rst_rdata", {40'd0, mem_rdata},      72'd0);
        chk("t6_rst_busy",  {71'd0, busy},           72'd0);
        step();
        step();
        resetn = 1'b1;
        issue(1'b0, 2'd3, 32'h7100, 32'h0);
        bif.data_addr_ok = 1'b1;
        exp_req.push_back({1'b0, 2'd2, 32'h7100, 32'h0});
        exp_rsp.push_back('{chk_data: 1'b1, data: 32'h0F0F0F0F});
        sample();
        chk("t6_new_req",  {71'd0, bif.data_req},  72'd1);
        chk("t6_new_size", {70'd0, bif.data_size}, 72'd2);
        step();
        bif.data_addr_ok = 1'b0;
        bif.data_data_ok = 1'b1;
        bif.data_rdata   = 32'h0F0F0F0F;
        mem_advance      = 1'b1;
        sample();
        chk("t6_new_acc", {71'd0, mem_acc_ok}, 72'd1);
        step();
        idle();
        sample();
        chk("t6_idle", {71'd0, busy}, 72'd0);

        chk("req_queue_empty", 72'(exp_req.size()), 72'd0);
        chk("rsp_queue_empty", 72'(exp_rsp.size()), 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
